zet_front_prefetch_wbq: RTL and testbench

ZET_FRONT_PREFETCH_WBQ -- requirements
Module: zet_front_prefetch_wbq

---
 rtl/zet_front_pkg.sv | 23 ++
 rtl/zet_front_fifo.sv | 65 ++++++
 rtl/zet_front_prefetch_wbq.sv | 130 +++++++++++++
 tb/tb_zet_front_prefetch_wbq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zet_front_pkg.sv
// Shared definitions for the prefetch front end.
// Holds fetch FSM states, reset vector defaults and the segment:offset address helper.
package zet_front_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [15:0] RST_CS_DEF = 16'hf000;
  localparam logic [15:0] RST_IP_DEF = 16'hfff0;

  // Queue entry layout: {dat[15:0], ip[15:0], cs[15:0], odd}
  localparam int unsigned ENTRY_W = 49;

  // Word address of cs:ip, i.e. ((cs<<4) + even ip) >> 1, wrapping at 1 MiB.
  function automatic logic [18:0] fetch_word_addr(input logic [15:0] cs,
                                                  input logic [14:0] ip_word);
    fetch_word_addr = {cs, 3'b000} + {4'h0, ip_word};
  endfunction

endpackage

// File: rtl/zet_front_fifo.sv
// Show-ahead instruction queue with synchronous clear.
// Pops on an empty queue and pushes on a full queue (without a pop) are ignored.
module zet_front_fifo #(
  parameter int unsigned AW = 3,
  parameter int unsigned W  = 49
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int unsigned   DEPTH    = 2 ** AW;
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_LVL  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign pop_ok_s  = pop && (level_r != {(AW + 1){1'b0}});
  assign push_ok_s = push && ((level_r != FULL_LVL) || pop_ok_s);

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + ONE_LVL;
        2'b01:   level_r <= level_r - ONE_LVL;
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array; contents need no reset because reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = (level_r == {(AW + 1){1'b0}}) ? {W{1'b0}} : mem_r[rd_ptr_r];
  assign empty = (level_r == {(AW + 1){1'b0}});
  assign full  = (level_r == FULL_LVL);
  assign level = level_r;

endmodule

// File: rtl/zet_front_prefetch_wbq.sv
// Instruction prefetcher: fetches words at cs:ip over Wishbone into a small queue.
// A flush redirects fetching and discards both the queue and any in-flight word.
module zet_front_prefetch_wbq
  import zet_front_pkg::*;
#(
  parameter int unsigned FIFO_AW = 3,
  parameter logic [15:0] RST_CS  = RST_CS_DEF,
  parameter logic [15:0] RST_IP  = RST_IP_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [15:0]        wb_dat_i,
  output logic [19:1]        wb_adr_o,
  output logic [1:0]         wb_sel_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  input  logic               wb_ack_i,
  input  logic               flush,
  input  logic [15:0]        requested_cs,
  input  logic [15:0]        requested_ip,
  input  logic               rd_fifo,
  output logic [15:0]        fifo_dat_o,
  output logic [15:0]        fifo_ip_o,
  output logic [15:0]        fifo_cs_o,
  output logic               fifo_odd_o,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int unsigned    DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] LAST_LVL = (FIFO_AW + 1)'(DEPTH - 1);
  localparam logic [18:0]    RST_ADR  = fetch_word_addr(RST_CS, RST_IP[15:1]);

  fetch_state_e         state_r;
  fetch_state_e         state_next_s;
  logic [15:0]          cs_r;
  logic [15:0]          ip_r;
  logic [15:0]          cs_next_s;
  logic [15:0]          ip_next_s;
  logic [15:0]          ip_even_s;
  logic [18:0]          adr_r;
  logic                 cyc_r;
  logic                 push_s;
  logic                 pop_eff_s;
  logic                 slot_left_s;
  logic                 fifo_full_s;
  logic [ENTRY_W-1:0]   wdata_s;
  logic [ENTRY_W-1:0]   rdata_s;

  assign ip_even_s   = {ip_r[15:1], 1'b0};
  assign pop_eff_s   = rd_fifo && !fifo_empty;
  // After a push a slot remains if a pop frees one or the queue was not one short of full.
  assign slot_left_s = pop_eff_s || (fifo_level < LAST_LVL);
  assign wdata_s     = {wb_dat_i, ip_even_s, cs_r, ip_r[0]};

  // Next-state, cs:ip update and push decision.
  always_comb begin
    state_next_s = state_r;
    cs_next_s    = flush ? requested_cs : cs_r;
    ip_next_s    = flush ? requested_ip : ip_r;
    push_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!flush && !fifo_full_s) state_next_s = ST_FETCH;
        else                        state_next_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (flush) begin
          if (wb_ack_i) state_next_s = ST_IDLE;
          else          state_next_s = ST_DRAIN;
        end else if (wb_ack_i) begin
          push_s    = 1'b1;
          ip_next_s = ip_even_s + 16'd2;
          if (slot_left_s) state_next_s = ST_FETCH;
          else             state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (wb_ack_i) state_next_s = ST_IDLE;
        else          state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, cs:ip and Wishbone request registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      cs_r    <= RST_CS;
      ip_r    <= RST_IP;
      cyc_r   <= 1'b0;
      adr_r   <= RST_ADR;
    end else begin
      state_r <= state_next_s;
      cs_r    <= cs_next_s;
      ip_r    <= ip_next_s;
      cyc_r   <= (state_next_s != ST_IDLE);
      // Address only moves when a new fetch starts, so it stays stable while draining.
      if (state_next_s == ST_FETCH) adr_r <= fetch_word_addr(cs_next_s, ip_next_s[15:1]);
      else                          adr_r <= adr_r;
    end
  end

  zet_front_fifo #(
    .AW (FIFO_AW),
    .W  (ENTRY_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (flush),
    .push  (push_s),
    .pop   (rd_fifo && !flush),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .empty (fifo_empty),
    .full  (fifo_full_s),
    .level (fifo_level)
  );

  assign {fifo_dat_o, fifo_ip_o, fifo_cs_o, fifo_odd_o} = rdata_s;

  assign wb_adr_o = adr_r;
  assign wb_sel_o = 2'b11;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;

endmodule

// File: tb/tb_zet_front_prefetch_wbq.sv
// Randomised bench for the prefetcher: the bench plays the Wishbone slave and
// tracks cs:ip and the expected queue contents with a transaction-level model.
module tb_zet_front_prefetch_wbq;
  import zet_front_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] wb_dat_i = 16'h0;
  logic [19:1] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] requested_cs = 16'h0, requested_ip = 16'h0;
  logic        rd_fifo = 1'b0;
  logic [15:0] fifo_dat_o, fifo_ip_o, fifo_cs_o;
  logic        fifo_odd_o, fifo_empty;
  logic [AW:0] fifo_level;

  always #5 wb_clk_i = ~wb_clk_i;

  zet_front_prefetch_wbq #(.FIFO_AW(AW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_dat_i(wb_dat_i),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .flush(flush),
    .requested_cs(requested_cs), .requested_ip(requested_ip),
    .rd_fifo(rd_fifo), .fifo_dat_o(fifo_dat_o), .fifo_ip_o(fifo_ip_o),
    .fifo_cs_o(fifo_cs_o), .fifo_odd_o(fifo_odd_o), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level)
  );

  typedef struct {
    logic [15:0] dat;
    logic [15:0] ip;
    logic [15:0] cs;
    logic        odd;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_cs, m_ip;
  bit          m_stale;
  int          idle_cnt;
  int          ack_total;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [19:1] exp_adr(input logic [15:0] cs, input logic [15:0] ip);
    logic [19:0] b;
    b = {cs, 4'h0} + {4'h0, ip & 16'hfffe};
    return b[19:1];
  endfunction

  task automatic model_reset();
    q.delete();
    m_cs     = RST_CS_DEF;
    m_ip     = RST_IP_DEF;
    m_stale  = 1'b0;
    idle_cnt = 0;
  endtask

  task automatic do_reset();
    wb_ack_i = 1'b0; flush = 1'b0; rd_fifo = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    model_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare at the falling edge.
  task automatic cycle(input bit ack, input bit fl, input logic [15:0] rcs,
                       input logic [15:0] rip, input bit rd);
    bit   cyc_s;
    ent_t e;
    cyc_s        = wb_cyc_o;
    wb_ack_i     = ack && cyc_s;
    wb_dat_i     = 16'($urandom);
    flush        = fl;
    requested_cs = rcs;
    requested_ip = rip;
    rd_fifo      = rd;
    if (fl) begin
      q.delete();
      m_cs = rcs;
      m_ip = rip;
      if (cyc_s) m_stale = !wb_ack_i;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (cyc_s && wb_ack_i) begin
        if (!m_stale) begin
          e.dat = wb_dat_i; e.ip = m_ip & 16'hfffe; e.cs = m_cs; e.odd = m_ip[0];
          q.push_back(e);
          m_ip = e.ip + 16'd2;
          ack_total++;
        end
        m_stale = 1'b0;
      end
    end
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_total++;
    if (fifo_level !== (AW + 1)'(q.size()))
      $display("FAIL level: got %0d exp %0d", fifo_level, q.size());
    else n_pass++;
    n_total++;
    if (fifo_empty !== (q.size() == 0))
      $display("FAIL empty: got %b exp %b", fifo_empty, q.size() == 0);
    else n_pass++;
    n_total++;
    if (q.size() > 0) begin
      if ({fifo_dat_o, fifo_ip_o, fifo_cs_o, fifo_odd_o} !== {q[0].dat, q[0].ip, q[0].cs, q[0].odd})
        $display("FAIL head: got %h/%h/%h/%b exp %h/%h/%h/%b", fifo_dat_o, fifo_ip_o,
                 fifo_cs_o, fifo_odd_o, q[0].dat, q[0].ip, q[0].cs, q[0].odd);
      else n_pass++;
    end else begin
      if ({fifo_dat_o, fifo_ip_o, fifo_cs_o, fifo_odd_o} !== 49'h0)
        $display("FAIL head_empty: got %h/%h/%h/%b exp zeros", fifo_dat_o, fifo_ip_o,
                 fifo_cs_o, fifo_odd_o);
      else n_pass++;
    end
    n_total++;
    if (wb_stb_o !== wb_cyc_o || wb_sel_o !== 2'b11)
      $display("FAIL stb_sel: got stb %b cyc %b sel %b exp stb=cyc sel 11", wb_stb_o, wb_cyc_o, wb_sel_o);
    else n_pass++;
    if (wb_cyc_o && !m_stale) begin
      n_total++;
      if (wb_adr_o !== exp_adr(m_cs, m_ip))
        $display("FAIL adr: got %h exp %h", wb_adr_o, exp_adr(m_cs, m_ip));
      else n_pass++;
    end
    if (q.size() == DEPTH) begin
      n_total++;
      if (wb_cyc_o !== 1'b0) $display("FAIL cyc_full: got %b exp 0", wb_cyc_o);
      else n_pass++;
    end
    if (!wb_cyc_o && q.size() < DEPTH && !fl) idle_cnt++;
    else idle_cnt = 0;
    n_total++;
    if (idle_cnt > 1) $display("FAIL fetch_stall: idle %0d cycles exp <= 1", idle_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({wb_cyc_o, wb_stb_o, fifo_empty, fifo_odd_o} !== 4'b0010)
      $display("FAIL reset_ctl: got cyc %b stb %b empty %b odd %b exp 0 0 1 0",
               wb_cyc_o, wb_stb_o, fifo_empty, fifo_odd_o);
    else n_pass++;
    n_total++;
    if ({fifo_level, fifo_dat_o, fifo_ip_o, fifo_cs_o} !== 52'h0)
      $display("FAIL reset_data: got lvl %0d %h %h %h exp zeros", fifo_level, fifo_dat_o, fifo_ip_o, fifo_cs_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_fill();
    do_reset();
    ack_total = 0;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (wb_adr_o !== 19'h7fff8) $display("FAIL first_adr: got %h exp 7fff8", wb_adr_o);
    else n_pass++;
    repeat (16) cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (ack_total != DEPTH || fifo_level !== 4'd8 || wb_cyc_o !== 1'b0)
      $display("FAIL fill: got words %0d lvl %0d cyc %b exp 8 8 0", ack_total, fifo_level, wb_cyc_o);
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    do_reset();
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h1234, 16'h0005, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (fifo_level !== 4'd0 || wb_cyc_o !== 1'b0)
      $display("FAIL stale_drop: got lvl %0d cyc %b exp 0 0", fifo_level, wb_cyc_o);
    else n_pass++;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (wb_adr_o !== 19'h091a2) $display("FAIL redirect_adr: got %h exp 091a2", wb_adr_o);
    else n_pass++;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if ({fifo_odd_o, fifo_ip_o, fifo_cs_o} !== {1'b1, 16'h0004, 16'h1234})
      $display("FAIL odd_entry: got odd %b ip %h cs %h exp 1 0004 1234", fifo_odd_o, fifo_ip_o, fifo_cs_o);
    else n_pass++;
    n_total++;
    if (wb_adr_o !== 19'h091a3) $display("FAIL next_ip_adr: got %h exp 091a3", wb_adr_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b1, 16'hffff, 16'hfffe, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (wb_adr_o !== 19'h07ff7) $display("FAIL wrap_adr: got %h exp 07ff7", wb_adr_o);
    else n_pass++;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (wb_adr_o !== 19'h7fff8) $display("FAIL wrap_next_adr: got %h exp 7fff8", wb_adr_o);
    else n_pass++;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    n_total++;
    if (fifo_ip_o !== 16'h0000 || fifo_cs_o !== 16'hffff)
      $display("FAIL wrap_ip: got ip %h cs %h exp 0000 ffff", fifo_ip_o, fifo_cs_o);
    else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [AW:0] lvl_b;
    bit          both;
    do_reset();
    repeat (16) cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      lvl_b = fifo_level;
      both  = wb_cyc_o && !m_stale && (fifo_level != '0);
      cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
      if (both) begin
        n_total++;
        if (fifo_level !== lvl_b) $display("FAIL pushpop_level: got %0d exp %0d", fifo_level, lvl_b);
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush_ack();
    do_reset();
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 16'h2000, 16'h0010, 1'b1);
    n_total++;
    if (fifo_level !== 4'd0 || fifo_empty !== 1'b1 || wb_cyc_o !== 1'b0)
      $display("FAIL flush_ack: got lvl %0d empty %b cyc %b exp 0 1 0", fifo_level, fifo_empty, wb_cyc_o);
    else n_pass++;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    n_total++;
    if (fifo_level !== 4'd0 || wb_adr_o !== 19'h10008)
      $display("FAIL pop_empty: got lvl %0d adr %h exp 0 10008", fifo_level, wb_adr_o);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, 16'($urandom),
            16'($urandom), $urandom_range(0, 1) == 1);
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #2 wb_rst_i = 1'b1;
    #1;
    model_reset();
    n_total++;
    if ({wb_cyc_o, wb_stb_o, fifo_empty, fifo_odd_o} !== 4'b0010)
      $display("FAIL midrst_ctl: got cyc %b stb %b empty %b odd %b exp 0 0 1 0",
               wb_cyc_o, wb_stb_o, fifo_empty, fifo_odd_o);
    else n_pass++;
    n_total++;
    if ({fifo_level, fifo_dat_o, fifo_ip_o, fifo_cs_o} !== 52'h0)
      $display("FAIL midrst_data: got lvl %0d %h %h %h exp zeros", fifo_level, fifo_dat_o, fifo_ip_o, fifo_cs_o);
    else n_pass++;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    n_total++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 19'h7fff8)
      $display("FAIL midrst_refetch: got cyc %b adr %h exp 1 7fff8", wb_cyc_o, wb_adr_o);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    ack_total = 0;
    test_reset();
    test_fill();
    test_flush_stall();
    test_wrap();
    test_full_pushpop();
    test_flush_ack();
    test_random();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
